// File: rtl/cmd_cntrl.sv
// cmd_cntrl -- command-and-control block of the line-follower robot.
//
// Decodes go-to-station / stop commands, latches the destination ID and
// compares incoming station IDs against it. in_transit tells the motion
// controller to run (1) or halt (0). Both inputs are consumed through a
// ready/clear handshake. The clear pulse blocks re-sampling for one cycle,
// which gives the source time to drop its request.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active HIGH (1 = reset)
//   cmd_rdy      new command present on cmd
//   cmd[7:0]     [7:6] opcode (00 stop, 01 go, 1x invalid), [5:0] dest ID
//   clr_cmd_rdy  one-cycle acknowledge of a consumed command
//   ID_vld       new station ID present on ID
//   ID[7:0]      [7:6] must be 00 for a valid ID, [5:0] station number
//   clr_ID_vld   one-cycle acknowledge of a consumed ID
//   in_transit   1 = robot moving toward its destination
module cmd_cntrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  output logic       clr_cmd_rdy,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic [7:0] ID,
  output logic       in_transit
);

  typedef enum logic {ST_STOP = 1'b0, ST_GO = 1'b1} state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  state_t     state;
  logic [5:0] dest_ID;

  // An input is taken only while its clear pulse is low, so a request
  // still high during the acknowledge cycle is not consumed twice.
  logic cmd_take, id_take;
  logic cmd_go, cmd_stop, id_match;

  assign cmd_take = cmd_rdy & ~clr_cmd_rdy;
  assign id_take  = ID_vld  & ~clr_ID_vld;
  assign cmd_go   = cmd_take & (cmd[7:6] == OP_GO);
  assign cmd_stop = cmd_take & (cmd[7:6] == OP_STOP);
  // Compared against the destination held before this edge.
  assign id_match = id_take & (ID[7:6] == 2'b00) & (ID[5:0] == dest_ID);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= ST_STOP;
      in_transit  <= 1'b0;
      dest_ID     <= 6'd0;
      clr_cmd_rdy <= 1'b0;
      clr_ID_vld  <= 1'b0;
    end else begin
      // Every consumed input is acknowledged, whatever the state or opcode.
      clr_cmd_rdy <= cmd_take;
      clr_ID_vld  <= id_take;
      case (state)
        ST_STOP: begin
          if (cmd_go) begin
            dest_ID    <= cmd[5:0];
            in_transit <= 1'b1;
            state      <= ST_GO;
          end
        end
        ST_GO: begin
          // A valid command outranks an ID arrival on the same edge;
          // an invalid command falls through so a matching ID still stops.
          if (cmd_go) begin
            dest_ID    <= cmd[5:0];
            in_transit <= 1'b1;
          end else if (cmd_stop || id_match) begin
            in_transit <= 1'b0;
            state      <= ST_STOP;
          end
        end
        default: begin
          in_transit <= 1'b0;
          state      <= ST_STOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_cntrl.sv
// Directed bench for cmd_cntrl. Each transaction starts 1 time unit after a
// rising edge; outputs are sampled 1 unit after the consuming edge.
module tb_cmd_cntrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       clr_cmd_rdy;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       in_transit;

  int nvec = 0;
  int nmis = 0;

  cmd_cntrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_rdy    (cmd_rdy),
    .cmd        (cmd),
    .clr_cmd_rdy(clr_cmd_rdy),
    .ID_vld     (ID_vld),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .in_transit (in_transit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Command alone; checks ack, in_transit after the edge, and ack drop.
  task automatic send_cmd(input logic [7:0] c, input logic exp_it);
    cmd = c; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("cmd_ack", {7'd0, clr_cmd_rdy}, 8'd1);
    chk("cmd_it", {7'd0, in_transit}, {7'd0, exp_it});
    tick();
    chk("cmd_ack_end", {7'd0, clr_cmd_rdy}, 8'd0);
  endtask

  task automatic send_id(input logic [7:0] id, input logic exp_it);
    ID = id; ID_vld = 1'b1;
    tick();
    ID_vld = 1'b0;
    chk("id_ack", {7'd0, clr_ID_vld}, 8'd1);
    chk("id_it", {7'd0, in_transit}, {7'd0, exp_it});
    tick();
    chk("id_ack_end", {7'd0, clr_ID_vld}, 8'd0);
  endtask

  // Command and ID consumed on the same edge.
  task automatic send_both(input logic [7:0] c, input logic [7:0] id, input logic exp_it);
    cmd = c; cmd_rdy = 1'b1; ID = id; ID_vld = 1'b1;
    tick();
    cmd_rdy = 1'b0; ID_vld = 1'b0;
    chk("both_cmd_ack", {7'd0, clr_cmd_rdy}, 8'd1);
    chk("both_id_ack", {7'd0, clr_ID_vld}, 8'd1);
    chk("both_it", {7'd0, in_transit}, {7'd0, exp_it});
    tick();
  endtask

  initial begin
    rst_n = 1'b1; cmd_rdy = 1'b0; ID_vld = 1'b0; cmd = 8'h00; ID = 8'h00;
    repeat (5) tick();
    chk("rst_it", {7'd0, in_transit}, 8'd0);
    chk("rst_clr_cmd", {7'd0, clr_cmd_rdy}, 8'd0);
    chk("rst_clr_id", {7'd0, clr_ID_vld}, 8'd0);
    @(negedge clk) rst_n = 1'b0;
    tick(); tick();
    chk("idle_it", {7'd0, in_transit}, 8'd0);
    chk("idle_clr_cmd", {7'd0, clr_cmd_rdy}, 8'd0);
    chk("idle_clr_id", {7'd0, clr_ID_vld}, 8'd0);

    // STOP: IDs discarded, STOP command acknowledged only.
    send_id(8'h05, 1'b0);
    send_cmd(8'h00, 1'b0);

    // GO to 0x10, walk IDs up to it.
    send_cmd(8'h50, 1'b1);
    for (int i = 5; i < 16; i++) send_id(8'(i), 1'b1);
    send_id(8'h10, 1'b0);

    // Invalid command in GO is acknowledged and ignored.
    send_cmd(8'h50, 1'b1);
    send_cmd(8'hCB, 1'b1);
    send_id(8'h10, 1'b0);

    // Destination retarget; old ID and bad-prefix ID do not stop.
    send_cmd(8'h50, 1'b1);
    send_cmd(8'h51, 1'b1);
    send_id(8'h10, 1'b1);
    send_id(8'h51, 1'b1);
    send_id(8'h11, 1'b0);

    // Simultaneous GO + matching ID: GO wins, new destination taken.
    send_cmd(8'h52, 1'b1);
    send_both(8'h53, 8'h12, 1'b1);
    send_id(8'h12, 1'b1);
    send_id(8'h13, 1'b0);

    // Simultaneous invalid command + matching ID: ID stops.
    send_cmd(8'h54, 1'b1);
    send_both(8'hC0, 8'h14, 1'b0);

    // Simultaneous STOP + non-matching ID: STOP stops.
    send_cmd(8'h55, 1'b1);
    send_both(8'h00, 8'h3F, 1'b0);

    // cmd changes without cmd_rdy have no effect.
    send_cmd(8'h56, 1'b1);
    cmd = 8'h00;
    tick(); tick();
    chk("noise_it", {7'd0, in_transit}, 8'd1);
    chk("noise_ack", {7'd0, clr_cmd_rdy}, 8'd0);

    // Held cmd_rdy is re-consumed every second cycle.
    cmd = 8'h57; cmd_rdy = 1'b1;
    tick(); chk("hold_ack0", {7'd0, clr_cmd_rdy}, 8'd1);
    tick(); chk("hold_ack1", {7'd0, clr_cmd_rdy}, 8'd0);
    tick(); chk("hold_ack2", {7'd0, clr_cmd_rdy}, 8'd1);
    cmd_rdy = 1'b0;
    tick();

    // STOP command from GO.
    send_cmd(8'h00, 1'b0);

    // Asynchronous reset mid-GO, then a pending command after release.
    send_cmd(8'h58, 1'b1);
    #2 rst_n = 1'b1;
    #1 chk("async_rst_it", {7'd0, in_transit}, 8'd0);
    cmd = 8'h59; cmd_rdy = 1'b1;
    tick(); tick();
    chk("rst_hold_it", {7'd0, in_transit}, 8'd0);
    chk("rst_hold_ack", {7'd0, clr_cmd_rdy}, 8'd0);
    @(negedge clk) rst_n = 1'b0;
    tick();
    cmd_rdy = 1'b0;
    chk("post_rst_ack", {7'd0, clr_cmd_rdy}, 8'd1);
    chk("post_rst_it", {7'd0, in_transit}, 8'd1);
    send_id(8'h19, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
